conv_window_ctrl: RTL

//  Front-end of the LeNet conv stage. Buffers the incoming raster pixel stream in NUM_LINES circular line stores.

---
 rtl/conv_window_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/conv_window_ctrl.sv
// Line-buffered KxK window generator: raster pixels fill NUM_LINES circular line stores,
// and windows are scanned left to right over the oldest K lines under a valid/ready handshake.
`timescale 1ns/1ps
module conv_window_ctrl #(
  parameter int DATA_W    = 8,
  parameter int IMG_W     = 32,
  parameter int K         = 5,
  parameter int NUM_LINES = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_pixel_data,
  input  logic                  i_pixel_valid,
  output logic                  o_pixel_ready,
  output logic [K*K*DATA_W-1:0] o_window_data,
  output logic                  o_window_valid,
  input  logic                  i_window_ready,
  output logic                  o_line_retired
);

  localparam int LW = $clog2(NUM_LINES);
  localparam int CW = $clog2(IMG_W);
  localparam int FW = $clog2(NUM_LINES*IMG_W + 1);
  localparam int WW = K*K*DATA_W;

  localparam logic [FW-1:0] FULL_CNT  = FW'(NUM_LINES*IMG_W);
  localparam logic [FW-1:0] START_CNT = FW'(K*IMG_W);
  localparam logic [FW-1:0] LINE_PIX  = FW'(IMG_W);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W-K);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W-1);
  localparam logic [LW-1:0] LINE_MAX  = LW'(NUM_LINES-1);

  typedef enum logic [1:0] {IDLE, READ, RETIRE} state_t;

  function automatic logic [LW-1:0] line_wrap(input logic [LW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_LINES) s = s - NUM_LINES;
    return LW'(s);
  endfunction

  logic [DATA_W-1:0] mem [NUM_LINES][IMG_W];

  state_t          state, state_n;
  logic [FW-1:0]   fill_cnt;
  logic [LW-1:0]   wr_line, rd_line;
  logic [CW-1:0]   wr_col, rd_col;
  logic            accept, fire, retire;
  logic [WW-1:0]   win_p0;
  logic [WW-1:0]   win_p1;
  logic            vld_p1;

  assign o_pixel_ready  = (fill_cnt < FULL_CNT);
  assign accept         = i_pixel_valid & o_pixel_ready;
  assign o_window_data  = win_p1;
  assign o_window_valid = vld_p1;
  assign o_line_retired = retire;

  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_line][wr_col] <= i_pixel_data;
  end

  // stage p0: combinational gather of the window at (rd_line, rd_col); row 0 / col 0 land in the MSBs
  always_comb begin
    win_p0 = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_p0[(K*K-1-(r*K+c))*DATA_W +: DATA_W] = mem[line_wrap(rd_line, r)][rd_col + CW'(c)];
      end
    end
  end

  always_comb begin
    state_n = state;
    fire    = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_cnt >= START_CNT) state_n = READ;
      end
      READ: begin
        fire = !vld_p1 | i_window_ready;
        if (fire && rd_col == LAST_COL) state_n = RETIRE;
      end
      RETIRE: begin
        retire  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      fill_cnt <= '0;
      wr_line  <= '0;
      wr_col   <= '0;
      rd_line  <= '0;
      rd_col   <= '0;
      win_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_cnt + {{(FW-1){1'b0}}, accept} - (retire ? LINE_PIX : '0);
      if (accept) begin
        if (wr_col == COL_MAX) begin
          wr_col  <= '0;
          wr_line <= (wr_line == LINE_MAX) ? '0 : wr_line + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (retire) begin
        rd_col  <= '0;
        rd_line <= (rd_line == LINE_MAX) ? '0 : rd_line + 1'b1;
      end else if (fire) begin
        rd_col <= rd_col + 1'b1;
      end
      // stage p1: registered window; held until the consumer takes it
      if (fire) begin
        win_p1 <= win_p0;
        vld_p1 <= 1'b1;
      end else if (i_window_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule
